// File: rtl/exc_commit_unit_pkg.sv
// Shared CPU defines for exception commit: cause indices, exception codes,
// redirect entry encodings and the commit FSM states.
package exc_commit_unit_pkg;

  localparam int EXC_NUM = 8;

  // mem_exc bit positions; bit 0 is the highest-priority pipeline cause
  localparam int IDX_REFETCH    = 0;
  localparam int IDX_TLB_REFILL = 1;
  localparam int IDX_TLB_INV    = 2;
  localparam int IDX_RI         = 3;
  localparam int IDX_SYSCALL    = 4;
  localparam int IDX_BREAK      = 5;
  localparam int IDX_OVERFLOW   = 6;
  localparam int IDX_ERET       = 7;

  localparam logic [4:0] EX_INT  = 5'h00;
  localparam logic [4:0] EX_TLBL = 5'h02;
  localparam logic [4:0] EX_ADEL = 5'h04;
  localparam logic [4:0] EX_SYS  = 5'h08;
  localparam logic [4:0] EX_BP   = 5'h09;
  localparam logic [4:0] EX_RI   = 5'h0a;
  localparam logic [4:0] EX_OV   = 5'h0c;
  localparam logic [4:0] EX_None = 5'h1f;

  localparam logic [1:0] IsNone      = 2'd0;
  localparam logic [1:0] IsException = 2'd1;
  localparam logic [1:0] IsEret      = 2'd2;
  localparam logic [1:0] IsRefetch   = 2'd3;

  // Priority-ordered cause vector: refetch, interrupt, misalign, mem_exc[1..]
  localparam int NCAUSE = EXC_NUM + 2;
  localparam int PRI_W  = 4;
  localparam logic [PRI_W-1:0] PRI_REFETCH    = 4'd0;
  localparam logic [PRI_W-1:0] PRI_INT        = 4'd1;
  localparam logic [PRI_W-1:0] PRI_MISALIGN   = 4'd2;
  localparam logic [PRI_W-1:0] PRI_TLB_REFILL = 4'(IDX_TLB_REFILL + 2);
  localparam logic [PRI_W-1:0] PRI_ERET       = 4'(IDX_ERET + 2);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_REDIRECT} state_e;

  function automatic logic [4:0] exc_code_of(input logic [PRI_W-1:0] pri);
    case (pri)
      PRI_REFETCH:                exc_code_of = EX_None;
      PRI_INT:                    exc_code_of = EX_INT;
      PRI_MISALIGN:               exc_code_of = EX_ADEL;
      4'(IDX_TLB_REFILL + 2),
      4'(IDX_TLB_INV + 2):        exc_code_of = EX_TLBL;
      4'(IDX_RI + 2):             exc_code_of = EX_RI;
      4'(IDX_SYSCALL + 2):        exc_code_of = EX_SYS;
      4'(IDX_BREAK + 2):          exc_code_of = EX_BP;
      4'(IDX_OVERFLOW + 2):       exc_code_of = EX_OV;
      default:                    exc_code_of = EX_None;
    endcase
  endfunction

endpackage

// File: rtl/exc_commit_unit_int_sync.sv
// Multi-flop synchronizer for asynchronous interrupt lines.
module int_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/exc_commit_unit.sv
// Exception/interrupt commit: picks the winning MEM-stage cause, drains,
// flushes the pipe and hands the vector target to fetch.
module exc_commit_unit
  import exc_commit_unit_pkg::*;
#(
  parameter int          NUM_HW_INT   = 6,
  parameter int          SYNC_STAGES  = 2,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] BOOT_BASE    = 32'hBFC00200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_pc,
  input  logic [EXC_NUM-1:0]    mem_exc,
  input  logic                  cp0_bev,
  input  logic                  cp0_exl,
  input  logic                  cp0_ie,
  input  logic                  cp0_iv,
  input  logic [NUM_HW_INT+1:0] cp0_im,
  input  logic [1:0]            cp0_ip_sw,
  input  logic [31:0]           cp0_ebase,
  input  logic [31:0]           cp0_epc,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  drain_busy,
  input  logic                  redirect_ready,
  output logic [NUM_HW_INT-1:0] hw_ip,
  output logic                  stall_mem,
  output logic                  exc_valid,
  output logic [4:0]            exc_code,
  output logic [1:0]            entry_sel,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc
);

  localparam logic [1:0] CNT_LAST = 2'(FLUSH_CYCLES - 1);

  int_sync #(.W(NUM_HW_INT), .STAGES(SYNC_STAGES)) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (hw_int),
    .q   (hw_ip)
  );

  state_e            st, st_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [4:0]        code_q;
  logic [1:0]        entry_q;
  logic [31:0]       pc_q;

  logic              int_req, evt;
  logic [NCAUSE-1:0] cause;
  logic [PRI_W-1:0]  win;
  logic [4:0]        c_code;
  logic [1:0]        c_entry;
  logic [31:0]       c_tgt, base, off;

  assign int_req = mem_valid && (mem_pc != 32'd0) && cp0_ie && !cp0_exl &&
                   (|({hw_ip, cp0_ip_sw} & cp0_im));
  assign cause   = {mem_exc[EXC_NUM-1:1], (mem_pc[1:0] != 2'b00), int_req,
                    mem_exc[IDX_REFETCH]};
  assign evt     = (st == S_IDLE) && mem_valid && (|cause);

  // lowest set index of the priority-ordered vector wins
  always_comb begin
    win = '0;
    for (int i = NCAUSE - 1; i >= 0; i--)
      if (cause[i]) win = PRI_W'(i);
  end

  always_comb begin
    base = cp0_bev ? BOOT_BASE : cp0_ebase;
    off  = 32'h180;
    if (win == PRI_INT && cp0_iv)         off = 32'h200;
    if (win == PRI_TLB_REFILL && !cp0_exl) off = 32'h000;
    c_code  = exc_code_of(win);
    c_entry = IsException;
    c_tgt   = base + off;
    if (win == PRI_REFETCH) begin
      c_entry = IsRefetch;
      c_tgt   = mem_pc;
    end else if (win == PRI_ERET) begin
      c_entry = IsEret;
      c_tgt   = cp0_epc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= S_IDLE;
      cnt     <= 2'd0;
      code_q  <= EX_None;
      entry_q <= IsNone;
      pc_q    <= 32'd0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      if (evt) begin
        code_q  <= c_code;
        entry_q <= c_entry;
        pc_q    <= c_tgt;
      end
    end
  end

  always_comb begin
    st_nxt         = st;
    cnt_nxt        = cnt;
    exc_code       = code_q;
    entry_sel      = entry_q;
    redirect_pc    = pc_q;
    flush          = 1'b0;
    exc_valid      = 1'b0;
    redirect_valid = 1'b0;
    stall_mem      = (st != S_IDLE) || evt;
    case (st)
      S_IDLE: begin
        exc_code  = evt ? c_code  : EX_None;
        entry_sel = evt ? c_entry : IsNone;
        if (evt) st_nxt = drain_busy ? S_DRAIN : S_FLUSH;
      end
      S_DRAIN: if (!drain_busy) st_nxt = S_FLUSH;
      S_FLUSH: begin
        flush     = 1'b1;
        exc_valid = (cnt == 2'd0);
        if (cnt == CNT_LAST) begin
          cnt_nxt = 2'd0;
          st_nxt  = S_REDIRECT;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) st_nxt = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exc_commit_unit.sv
// Randomized bench for exc_commit_unit against a cause-priority reference model.
module tb_exc_commit_unit;
  import exc_commit_unit_pkg::*;

  localparam int          NHW  = 6;
  localparam int          SS   = 2;
  localparam int          FC   = 3;
  localparam logic [31:0] BOOT = 32'hBFC00200;

  logic clk = 1'b0, rst = 1'b1;
  logic mem_valid = 0;
  logic [31:0] mem_pc = 0;
  logic [EXC_NUM-1:0] mem_exc = 0;
  logic cp0_bev = 0, cp0_exl = 0, cp0_ie = 0, cp0_iv = 0;
  logic [NHW+1:0] cp0_im = 0;
  logic [1:0] cp0_ip_sw = 0;
  logic [31:0] cp0_ebase = 0, cp0_epc = 0;
  logic [NHW-1:0] hw_int = 0;
  logic drain_busy = 0, redirect_ready = 0;
  logic [NHW-1:0] hw_ip;
  logic stall_mem, exc_valid, flush, redirect_valid;
  logic [4:0] exc_code;
  logic [1:0] entry_sel;
  logic [31:0] redirect_pc;

  exc_commit_unit #(.NUM_HW_INT(NHW), .SYNC_STAGES(SS), .FLUSH_CYCLES(FC),
                    .BOOT_BASE(BOOT)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_exc(mem_exc), .cp0_bev(cp0_bev), .cp0_exl(cp0_exl), .cp0_ie(cp0_ie),
    .cp0_iv(cp0_iv), .cp0_im(cp0_im), .cp0_ip_sw(cp0_ip_sw),
    .cp0_ebase(cp0_ebase), .cp0_epc(cp0_epc), .hw_int(hw_int),
    .drain_busy(drain_busy), .redirect_ready(redirect_ready), .hw_ip(hw_ip),
    .stall_mem(stall_mem), .exc_valid(exc_valid), .exc_code(exc_code),
    .entry_sel(entry_sel), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // exception code per mem_exc bit
  logic [4:0] code_of [EXC_NUM] = '{EX_None, EX_TLBL, EX_TLBL, EX_RI, EX_SYS,
                                    EX_BP, EX_OV, EX_None};

  // Reference: synchronized lines are assumed settled, so hw_ip == hw_int.
  task automatic model(output logic [4:0] code, output logic [1:0] ent,
                       output logic [31:0] tgt, output bit any);
    logic [31:0] base;
    bit intr, mis;
    int k;
    base = cp0_bev ? BOOT : cp0_ebase;
    intr = mem_valid && mem_pc != 0 && cp0_ie && !cp0_exl &&
           (({hw_int, cp0_ip_sw} & cp0_im) != 0);
    mis  = mem_pc[1:0] != 2'b00;
    any  = mem_valid && (mem_exc != 0 || intr || mis);
    code = EX_None; ent = IsNone; tgt = 0;
    if (!any) begin
    end else if (mem_exc[IDX_REFETCH]) begin
      ent = IsRefetch; tgt = mem_pc;
    end else if (intr) begin
      code = EX_INT; ent = IsException; tgt = base + (cp0_iv ? 32'h200 : 32'h180);
    end else if (mis) begin
      code = EX_ADEL; ent = IsException; tgt = base + 32'h180;
    end else begin
      k = 1;
      while (!mem_exc[k]) k++;
      code = code_of[k];
      if (k == IDX_ERET) begin
        ent = IsEret; tgt = cp0_epc;
      end else begin
        ent = IsException;
        tgt = base + ((k == IDX_TLB_REFILL && !cp0_exl) ? 32'h0 : 32'h180);
      end
    end
  endtask

  task automatic settle();
    mem_valid = 0;
    repeat (SS + 1) @(negedge clk);
    #1 chk("hw_ip_settled", 32'(hw_ip), 32'(hw_int));
  endtask

  // One committed event: drain_n DRAIN cycles, ready withheld ready_n cycles.
  task automatic do_txn(input int drain_n, input int ready_n, input bit jitter_hw);
    logic [4:0] e_code; logic [1:0] e_ent; logic [31:0] e_tgt; bit any;
    int r_last, total;
    @(negedge clk);
    mem_valid = 1; drain_busy = (drain_n > 0); redirect_ready = 0;
    #1 model(e_code, e_ent, e_tgt, any);
    chk("txn_has_cause", 32'(any), 32'd1);
    chk("stall_capture", 32'(stall_mem), 32'd1);
    chk("flush_capture", 32'(flush), 32'd0);
    r_last = drain_n + FC + ready_n + 1;
    total  = r_last + 1;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      mem_valid = 0;
      if (jitter_hw) hw_int = NHW'($urandom);
      drain_busy     = (c < drain_n);
      redirect_ready = (c == r_last);
      #1;
      chk("stall", 32'(stall_mem), 32'(c <= r_last));
      chk("flush", 32'(flush), 32'(c > drain_n && c <= drain_n + FC));
      chk("exc_valid", 32'(exc_valid), 32'(c == drain_n + 1));
      chk("redirect_valid", 32'(redirect_valid), 32'(c > drain_n + FC && c <= r_last));
      if (c <= r_last) begin
        chk("exc_code", 32'(exc_code), 32'(e_code));
        chk("entry_sel", 32'(entry_sel), 32'(e_ent));
        chk("redirect_pc", redirect_pc, e_tgt);
      end else begin
        chk("entry_idle", 32'(entry_sel), 32'(IsNone));
      end
    end
    redirect_ready = 0;
  endtask

  task automatic clear_inputs();
    mem_exc = 0; mem_pc = 32'h0040_0000;
    cp0_bev = 0; cp0_exl = 0; cp0_ie = 0; cp0_iv = 0; cp0_im = 0; cp0_ip_sw = 0;
    cp0_ebase = 32'h8000_0000; cp0_epc = 32'h8000_1234; hw_int = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, 32'(stall_mem), 0);
    chk({tag, "_exc_valid"}, 32'(exc_valid), 0);
    chk({tag, "_flush"}, 32'(flush), 0);
    chk({tag, "_redirect_valid"}, 32'(redirect_valid), 0);
    chk({tag, "_exc_code"}, 32'(exc_code), 32'(EX_None));
    chk({tag, "_entry_sel"}, 32'(entry_sel), 32'(IsNone));
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
    chk({tag, "_hw_ip"}, 32'(hw_ip), 0);
  endtask

  initial begin
    logic [4:0] e_code; logic [1:0] e_ent; logic [31:0] e_tgt; bit any;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst = 0;
    #1 chk_reset_outputs("reset");

    // Syscall, BEV=1, no drain
    clear_inputs(); cp0_bev = 1; mem_exc = EXC_NUM'(1 << IDX_SYSCALL);
    do_txn(0, 0, 0);
    chk("syscall_vector", redirect_pc, 32'hBFC00380);

    // TLB refill with drain_busy for 3 cycles
    clear_inputs(); mem_exc = EXC_NUM'(1 << IDX_TLB_REFILL);
    do_txn(3, 0, 0);

    // Interrupt synchronizer latency, then interrupt beats overflow
    clear_inputs(); settle();
    @(negedge clk); hw_int = 6'b000100;
    for (int k = 1; k <= SS; k++) begin
      @(negedge clk); #1 chk("hw_ip_latency", 32'(hw_ip[2]), 32'(k == SS));
    end
    cp0_ie = 1; cp0_iv = 1; cp0_im = 8'h10; mem_exc = EXC_NUM'(1 << IDX_OVERFLOW);
    do_txn(0, 1, 0);
    chk("int_vector", redirect_pc, 32'h80000200);

    // Refetch beats simultaneous interrupt
    mem_exc = EXC_NUM'(1 << IDX_REFETCH); mem_pc = 32'h8000_4440;
    do_txn(1, 0, 0);
    chk("refetch_target", redirect_pc, 32'h8000_4440);

    // Redirect held off 5 cycles
    clear_inputs(); mem_exc = EXC_NUM'(1 << IDX_BREAK);
    do_txn(0, 5, 0);

    // Reset while draining
    clear_inputs(); mem_exc = EXC_NUM'(1 << IDX_SYSCALL);
    @(negedge clk); mem_valid = 1; drain_busy = 1;
    @(negedge clk); mem_valid = 0;
    #1 chk("drain_stall", 32'(stall_mem), 1);
    rst = 1;
    @(negedge clk); rst = 0; drain_busy = 0;
    #1 chk_reset_outputs("rst_drain");
    mem_exc = EXC_NUM'(1 << IDX_RI);
    do_txn(0, 0, 0);

    // Randomized events
    for (int t = 0; t < 60; t++) begin
      clear_inputs();
      case ($urandom_range(0, 3))
        0: mem_exc = 0;
        1: mem_exc = EXC_NUM'(1 << $urandom_range(0, EXC_NUM - 1));
        default: mem_exc = EXC_NUM'((1 << $urandom_range(1, EXC_NUM - 1)) |
                                    (1 << $urandom_range(1, EXC_NUM - 1)));
      endcase
      mem_pc = $urandom;
      if ($urandom_range(0, 3) != 0) mem_pc[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) mem_pc = 0;
      {cp0_bev, cp0_exl, cp0_ie, cp0_iv} = 4'($urandom);
      cp0_ie = cp0_ie | ($urandom_range(0, 1) == 1);
      cp0_im = (NHW+2)'($urandom); cp0_ip_sw = 2'($urandom);
      cp0_ebase = $urandom & 32'hFFFF_F000; cp0_epc = $urandom;
      hw_int = NHW'($urandom);
      settle();
      mem_valid = 1;
      #1 model(e_code, e_ent, e_tgt, any);
      if (!any) begin
        chk("no_event_stall", 32'(stall_mem), 0);
        chk("no_event_entry", 32'(entry_sel), 32'(IsNone));
        @(negedge clk); mem_valid = 0;
        #1 chk("no_event_idle", 32'(stall_mem), 0);
      end else begin
        mem_valid = 0;
        do_txn($urandom_range(0, 3), $urandom_range(0, 3), 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
